// File: rtl/noc_pkg.sv
// Shared types for the NoC link transmitter.
//  - flit_type_e : 2-bit flit type carried in the top bits of every link word
//  - tx_state_e  : transmitter FSM states
//  - FLIT_TYPE_W : width of the flit type field
//  - STAT_W      : width of the optional statistics counters
//  - flit_type_of: type of flit number idx in a packet of pkt_flits flits
package noc_pkg;

  localparam int FLIT_TYPE_W = 2;
  localparam int STAT_W      = 32;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HEAD   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    FETCH   = 3'd2,
    SEND    = 3'd3,
    RELEASE = 3'd4
  } tx_state_e;

  // A one-flit packet is SINGLE; otherwise first is HEAD, last is TAIL,
  // everything in between is BODY.
  function automatic flit_type_e flit_type_of(input int idx, input int pkt_flits);
    flit_type_e t;
    if (pkt_flits == 1) begin
      t = SINGLE;
    end else if (idx == 0) begin
      t = HEAD;
    end else if (idx == pkt_flits - 1) begin
      t = TAIL;
    end else begin
      t = BODY;
    end
    return t;
  endfunction

endpackage : noc_pkg

// File: rtl/noc_tx_stats.sv
// Transmit statistics for noc_link_tx (only built with NOC_TX_STATS_EN).
// Ports:
//  clk_i, rst_i        clock, synchronous active-high reset
//  flit_done_i         one-cycle pulse when a flit's 4-phase handshake completes
//  pkt_done_i          one-cycle pulse when the completing flit closes a packet
//  tx_flit_count_o     completed flits since reset, wraps modulo 2^32
//  tx_pkt_count_o      completed packets since reset, wraps modulo 2^32
module noc_tx_stats
  import noc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flit_done_i,
  input  logic              pkt_done_i,
  output logic [STAT_W-1:0] tx_flit_count_o,
  output logic [STAT_W-1:0] tx_pkt_count_o
);

  logic [STAT_W-1:0] flit_cnt_q, flit_cnt_d;
  logic [STAT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (flit_done_i) flit_cnt_d = flit_cnt_q + 1'b1;
    if (pkt_done_i)  pkt_cnt_d  = pkt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign tx_flit_count_o = flit_cnt_q;
  assign tx_pkt_count_o  = pkt_cnt_q;

endmodule : noc_tx_stats

// File: rtl/noc_link_tx.sv
// Output-port transmitter: drains fixed-length packets from a local FWFT FIFO,
// takes link ownership from a locking port arbiter, then sends each word as a
// typed flit {flit_type, payload} over a 4-phase req/ack link.
// Optional feature macro: NOC_TX_STATS_EN adds tx_flit_count / tx_pkt_count.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  fifo_rd_en          pop the FIFO head (combinational, FETCH only)
//  fifo_wr_en/_wr_data tied 0
//  fifo_rd_data        FIFO head word, valid while !fifo_empty
//  fifo_full           unused
//  fifo_empty          FIFO has no word
//  fifo_pkt_address    unused
//  arb_req / arb_grant link ownership request / grant
//  link_data           flit to neighbour, stable while a handshake is open
//  link_req / link_ack 4-phase request / acknowledge
//  tx_flit_count       (NOC_TX_STATS_EN) completed flits
//  tx_pkt_count        (NOC_TX_STATS_EN) completed packets
//  dbg_state_o         current FSM state, for observation only
//
// Link handshake (4-phase): raise link_req with link_data stable; the receiver
// raises link_ack; drop link_req; the receiver drops link_ack. link_data only
// changes in FETCH, which is entered with link_ack low, so it never moves while
// the receiver may still be sampling it.
module noc_link_tx
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDRESS_SIZE = 4,
  parameter int PKT_FLITS    = 4,
  parameter int LINK_WIDTH   = DATA_WIDTH + FLIT_TYPE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    fifo_rd_en,
  output logic                    fifo_wr_en,
  output logic [DATA_WIDTH-1:0]   fifo_wr_data,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                    fifo_full,
  input  logic                    fifo_empty,
  input  logic [ADDRESS_SIZE-1:0] fifo_pkt_address,
  output logic                    arb_req,
  input  logic                    arb_grant,
  output logic [LINK_WIDTH-1:0]   link_data,
  output logic                    link_req,
  input  logic                    link_ack,
`ifdef NOC_TX_STATS_EN
  output logic [STAT_W-1:0]       tx_flit_count,
  output logic [STAT_W-1:0]       tx_pkt_count,
`endif
  output logic [2:0]              dbg_state_o
);

  localparam int CNT_W = $clog2(PKT_FLITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_FLITS - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      flit_cnt_q, flit_cnt_d;
  logic [LINK_WIDTH-1:0] link_data_q, link_data_d;
  logic                  arb_req_q;
  logic                  link_req_q;
  logic                  flit_done;
  logic                  pkt_done;

  always_comb begin
    state_d     = state_q;
    flit_cnt_d  = flit_cnt_q;
    link_data_d = link_data_q;
    fifo_rd_en  = 1'b0;
    flit_done   = 1'b0;
    pkt_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ARB;
      end
      ARB: begin
        if (arb_grant) begin
          state_d    = FETCH;
          flit_cnt_d = '0;
        end
      end
      FETCH: begin
        // Holding off while link_ack is still high keeps a stale ack (e.g.
        // left over from before a reset) from completing the new flit.
        if (!fifo_empty && !link_ack) begin
          fifo_rd_en  = 1'b1;
          link_data_d = {flit_type_of(int'(flit_cnt_q), PKT_FLITS), fifo_rd_data};
          state_d     = SEND;
        end
      end
      SEND: begin
        if (link_ack) state_d = RELEASE;
      end
      RELEASE: begin
        if (!link_ack) begin
          flit_done  = 1'b1;
          flit_cnt_d = flit_cnt_q + 1'b1;
          if (flit_cnt_q == CNT_LAST) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flit_cnt_q  <= '0;
      link_data_q <= '0;
      arb_req_q   <= 1'b0;
      link_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flit_cnt_q  <= flit_cnt_d;
      link_data_q <= link_data_d;
      // arb_req follows the owning states one cycle late; link_req is
      // registered from the next state so it coincides with SEND.
      arb_req_q   <= (state_q != IDLE);
      link_req_q  <= (state_d == SEND);
    end
  end

  assign arb_req      = arb_req_q;
  assign link_req     = link_req_q;
  assign link_data    = link_data_q;
  assign fifo_wr_en   = 1'b0;
  assign fifo_wr_data = '0;
  assign dbg_state_o  = state_q;

  // Routing is resolved upstream and the FIFO is only ever read here.
  logic unused_inputs;
  assign unused_inputs = ^{fifo_full, fifo_pkt_address};

`ifdef NOC_TX_STATS_EN
  noc_tx_stats u_stats (
    .clk_i           (clk),
    .rst_i           (rst),
    .flit_done_i     (flit_done),
    .pkt_done_i      (pkt_done),
    .tx_flit_count_o (tx_flit_count),
    .tx_pkt_count_o  (tx_pkt_count)
  );
`else
  logic unused_stats;
  assign unused_stats = flit_done ^ pkt_done;
`endif

endmodule : noc_link_tx

// File: tb/tb_noc_link_tx.sv
`timescale 1ns/1ps
module tb_noc_link_tx;

  localparam int DW = 16;
  localparam int LW = DW + 2;
  localparam int PA = 4;
  localparam int PB = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4-flit packets ----------------
  logic          a_rd_en, a_wr_en, a_arb_req, a_link_req;
  logic [DW-1:0] a_wr_data;
  logic [LW-1:0] a_link_data;
  logic [2:0]    a_dbg;
  logic [DW-1:0] a_rd_data = '0;
  logic          a_empty = 1'b1, a_full = 1'b0, a_grant = 1'b0, a_link_ack = 1'b0;
`ifdef NOC_TX_STATS_EN
  logic [31:0]   a_flit_cnt, a_pkt_cnt;
`endif

  noc_link_tx #(.DATA_WIDTH(DW), .ADDRESS_SIZE(4), .PKT_FLITS(PA)) u_dut (
    .clk(clk), .rst(rst),
    .fifo_rd_en(a_rd_en), .fifo_wr_en(a_wr_en), .fifo_wr_data(a_wr_data),
    .fifo_rd_data(a_rd_data), .fifo_full(a_full), .fifo_empty(a_empty),
    .fifo_pkt_address(4'h5),
    .arb_req(a_arb_req), .arb_grant(a_grant),
    .link_data(a_link_data), .link_req(a_link_req), .link_ack(a_link_ack),
`ifdef NOC_TX_STATS_EN
    .tx_flit_count(a_flit_cnt), .tx_pkt_count(a_pkt_cnt),
`endif
    .dbg_state_o(a_dbg)
  );

  // ---------------- DUT B: single-flit packets ----------------
  logic          b_rd_en, b_wr_en, b_arb_req, b_link_req;
  logic [DW-1:0] b_wr_data;
  logic [LW-1:0] b_link_data;
  logic [2:0]    b_dbg;
  logic [DW-1:0] b_rd_data = '0;
  logic          b_empty = 1'b1, b_grant = 1'b0, b_link_ack = 1'b0;
`ifdef NOC_TX_STATS_EN
  logic [31:0]   b_flit_cnt, b_pkt_cnt;
`endif

  noc_link_tx #(.DATA_WIDTH(DW), .ADDRESS_SIZE(4), .PKT_FLITS(PB)) u_dut1 (
    .clk(clk), .rst(rst),
    .fifo_rd_en(b_rd_en), .fifo_wr_en(b_wr_en), .fifo_wr_data(b_wr_data),
    .fifo_rd_data(b_rd_data), .fifo_full(1'b0), .fifo_empty(b_empty),
    .fifo_pkt_address(4'h0),
    .arb_req(b_arb_req), .arb_grant(b_grant),
    .link_data(b_link_data), .link_req(b_link_req), .link_ack(b_link_ack),
`ifdef NOC_TX_STATS_EN
    .tx_flit_count(b_flit_cnt), .tx_pkt_count(b_pkt_cnt),
`endif
    .dbg_state_o(b_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Flit type from position in packet.
  function automatic logic [1:0] exp_type(input int pos, input int pkt);
    if (pkt == 1) return 2'b11;
    if (pos == 0) return 2'b10;
    if (pos == pkt - 1) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- reference model state ----------------
  logic [DW-1:0] a_fifo_q[$];
  logic [LW-1:0] a_exp_q[$];
  logic [DW-1:0] b_fifo_q[$];
  logic [LW-1:0] b_exp_q[$];
  int a_pos = 0, a_pushed = 0, a_pops = 0, a_pops_since = 0;
  int b_pushed = 0, b_pops = 0;
  int exp_flits = 0, exp_pkts = 0;
  bit a_grant_en = 1'b1, a_force_ack = 1'b0;
  logic a_rd_s = 1'b0, a_req_s = 1'b0, a_arb_s = 1'b0, a_req_prev = 1'b0;
  logic b_rd_s = 1'b0, b_req_s = 1'b0, b_arb_s = 1'b0, b_req_prev = 1'b0;
  logic [LW-1:0] a_data_prev = '0, b_data_prev = '0, b_last_flit = '0;

  task automatic fifo_refresh();
    a_empty   = (a_fifo_q.size() == 0);
    a_rd_data = a_empty ? '0 : a_fifo_q[0];
    b_empty   = (b_fifo_q.size() == 0);
    b_rd_data = b_empty ? '0 : b_fifo_q[0];
  endtask

  // Observation on the falling edge: scoreboard and sampling for responders.
  always @(negedge clk) begin
    logic [LW-1:0] e;
    a_rd_s = a_rd_en; a_req_s = a_link_req; a_arb_s = a_arb_req;
    if (a_link_req && !a_req_prev) begin
      if (a_exp_q.size() == 0) begin
        check_eq("a_extra_flit", a_exp_q.size(), 1);
      end else begin
        e = a_exp_q.pop_front();
        check_eq("a_flit", a_link_data, e);
        check_eq("a_pops_per_flit", a_pops_since, 1);
        a_pops_since = 0;
        exp_flits++;
        if (e[LW-1 -: 2] == 2'b01) exp_pkts++;
      end
    end else if (a_link_req) begin
      check_eq("a_data_stable", a_link_data, a_data_prev);
    end
    a_req_prev = a_link_req; a_data_prev = a_link_data;

    b_rd_s = b_rd_en; b_req_s = b_link_req; b_arb_s = b_arb_req;
    if (b_link_req && !b_req_prev) begin
      if (b_exp_q.size() == 0) begin
        check_eq("b_extra_flit", b_exp_q.size(), 1);
      end else begin
        e = b_exp_q.pop_front();
        check_eq("b_flit", b_link_data, e);
        b_last_flit = b_link_data;
      end
    end else if (b_link_req) begin
      check_eq("b_data_stable", b_link_data, b_data_prev);
    end
    b_req_prev = b_link_req; b_data_prev = b_link_data;
  end

  // Responders just after the rising edge: FIFO pop, ack echo, locking arbiter.
  always @(posedge clk) begin
    #1;
    if (a_rd_s) begin
      if (a_fifo_q.size() == 0) check_eq("a_pop_when_empty", a_fifo_q.size(), 1);
      else begin void'(a_fifo_q.pop_front()); a_pops++; a_pops_since++; end
    end
    if (b_rd_s) begin
      if (b_fifo_q.size() == 0) check_eq("b_pop_when_empty", b_fifo_q.size(), 1);
      else begin void'(b_fifo_q.pop_front()); b_pops++; end
    end
    a_link_ack = a_force_ack | a_req_s;
    b_link_ack = b_req_s;
    a_grant    = a_grant_en & a_arb_s;
    b_grant    = b_arb_s;
    a_full     = 1'($urandom_range(0, 1));
    fifo_refresh();
  end

  // ---------------- driver tasks ----------------
  task automatic push_a(input logic [DW-1:0] w);
    a_fifo_q.push_back(w);
    a_exp_q.push_back({exp_type(a_pos, PA), w});
    a_pos = (a_pos + 1) % PA;
    a_pushed++;
    fifo_refresh();
  endtask

  task automatic push_b(input logic [DW-1:0] w);
    b_fifo_q.push_back(w);
    b_exp_q.push_back({exp_type(0, PB), w});
    b_pushed++;
    fifo_refresh();
  endtask

  task automatic clear_models();
    a_fifo_q.delete(); a_exp_q.delete(); b_fifo_q.delete(); b_exp_q.delete();
    a_pos = 0; a_pushed = 0; a_pops = 0; a_pops_since = 0;
    b_pushed = 0; b_pops = 0; exp_flits = 0; exp_pkts = 0;
    fifo_refresh();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a_rd_en"}, a_rd_en, 0);
    check_eq({tag, "_a_arb_req"}, a_arb_req, 0);
    check_eq({tag, "_a_link_req"}, a_link_req, 0);
    check_eq({tag, "_a_link_data"}, a_link_data, 0);
    check_eq({tag, "_a_wr"}, {a_wr_en, a_wr_data}, 0);
    check_eq({tag, "_b_outs"}, {b_rd_en, b_arb_req, b_link_req, b_link_data, b_wr_en, b_wr_data}, 0);
`ifdef NOC_TX_STATS_EN
    check_eq({tag, "_a_stats"}, {a_flit_cnt, a_pkt_cnt}, 0);
    check_eq({tag, "_b_stats"}, {b_flit_cnt, b_pkt_cnt}, 0);
`endif
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_outputs(tag);
    rst = 1'b0;
    clear_models();
  endtask

  task automatic wait_quiet_a(input string tag, input int max_cycles);
    int n = 0;
    while (n < max_cycles && !(a_exp_q.size() == 0 && a_fifo_q.size() == 0 &&
           !a_arb_req && !a_link_req && !a_link_ack)) begin
      @(negedge clk); n++;
    end
    check_eq({tag, "_timeout"}, 64'(n >= max_cycles), 0);
    check_eq({tag, "_pops"}, a_pops, a_pushed);
  endtask

  task automatic wait_quiet_b(input string tag, input int max_cycles);
    int n = 0;
    while (n < max_cycles && !(b_exp_q.size() == 0 && b_fifo_q.size() == 0 &&
           !b_arb_req && !b_link_req && !b_link_ack)) begin
      @(negedge clk); n++;
    end
    check_eq({tag, "_timeout"}, 64'(n >= max_cycles), 0);
    check_eq({tag, "_pops"}, b_pops, b_pushed);
  endtask

  task automatic check_stats(input string tag);
`ifdef NOC_TX_STATS_EN
    check_eq({tag, "_flit_count"}, a_flit_cnt, exp_flits);
    check_eq({tag, "_pkt_count"}, a_pkt_cnt, exp_pkts);
`else
    check_eq({tag, "_arb_idle"}, a_arb_req, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    do_reset("reset");

    // T1: one 4-flit packet with latency checks.
    @(posedge clk); #3;
    for (int i = 0; i < 4; i++) push_a(16'hA0A0 + 16'(i));
    @(negedge clk); check_eq("t1_arb_req_c0", a_arb_req, 0);
    @(negedge clk); check_eq("t1_arb_req_c1", a_arb_req, 0);
    @(negedge clk); check_eq("t1_arb_req_c2", a_arb_req, 1);
    @(negedge clk); check_eq("t1_grant_c3", a_grant, 1); check_eq("t1_rd_en_c3", a_rd_en, 0);
    @(negedge clk); check_eq("t1_rd_en_c4", a_rd_en, 1); check_eq("t1_link_req_c4", a_link_req, 0);
    @(negedge clk); check_eq("t1_link_req_c5", a_link_req, 1); check_eq("t1_rd_en_c5", a_rd_en, 0);
    wait_quiet_a("t1", 100);
    check_eq("t1_four_pops", a_pops, 4);

    // T2: single-flit packets on DUT B.
    @(posedge clk); #3; push_b(16'h00FF);
    wait_quiet_b("t2", 50);
    check_eq("t2_flit_value", b_last_flit, 18'h300FF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3; push_b(DW'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_quiet_b("t2_rand", 100);

    // T3: grant withheld for 10 cycles.
    a_grant_en = 1'b0;
    @(posedge clk); #3;
    for (int i = 0; i < 4; i++) push_a(DW'($urandom));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t3_arb_req_held", a_arb_req, 1);
      check_eq("t3_no_link_req", a_link_req, 0);
      check_eq("t3_no_pop", a_rd_en, 0);
    end
    check_eq("t3_pops_unchanged", a_pops, a_pushed - 4);
    @(posedge clk); #3; a_grant_en = 1'b1;
    @(negedge clk); check_eq("t3_rd_en_g0", a_rd_en, 0);
    @(negedge clk); check_eq("t3_grant_seen", a_grant, 1); check_eq("t3_rd_en_g1", a_rd_en, 0);
    @(negedge clk); check_eq("t3_first_pop", a_rd_en, 1);
    wait_quiet_a("t3", 100);

    // T4: FIFO runs dry after flit 1.
    @(posedge clk); #3;
    push_a(DW'($urandom)); push_a(DW'($urandom));
    n = 0;
    while (n < 60 && !(a_exp_q.size() == 0 && !a_link_req && !a_link_ack)) begin
      @(negedge clk); n++;
    end
    check_eq("t4_two_flits_sent", 64'(n < 60), 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_stall_link_req", a_link_req, 0);
      check_eq("t4_stall_arb_req", a_arb_req, 1);
      check_eq("t4_stall_no_pop", a_rd_en, 0);
    end
    @(posedge clk); #3;
    push_a(DW'($urandom)); push_a(DW'($urandom));
    wait_quiet_a("t4", 100);

    // T5: reset in SEND with link_ack held high.
    @(posedge clk); #3;
    for (int i = 0; i < 4; i++) push_a(DW'($urandom));
    n = 0;
    while (!a_link_req && n < 50) begin @(negedge clk); n++; end
    check_eq("t5_send_reached", 64'(n < 50), 1);
    a_force_ack = 1'b1; rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5");
    rst = 1'b0;
    clear_models();
    @(posedge clk); #3;
    for (int i = 0; i < 4; i++) push_a(DW'($urandom));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_eq("t5_no_link_req", a_link_req, 0);
      check_eq("t5_no_pop", a_rd_en, 0);
    end
    check_eq("t5_arb_req", a_arb_req, 1);
    @(posedge clk); #3; a_force_ack = 1'b0;
    wait_quiet_a("t5", 100);
    check_stats("t5");

    // Randomized stream with gaps and grant toggling.
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #3;
      push_a(DW'($urandom));
      if ($urandom_range(0, 5) == 0) a_grant_en = ~a_grant_en;
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    @(posedge clk); #3; a_grant_en = 1'b1;
    wait_quiet_a("rand", 800);
    check_stats("rand");

    // T6: three packets after reset.
    do_reset("t6_reset");
    @(posedge clk); #3;
    for (int i = 0; i < 12; i++) push_a(DW'($urandom));
    wait_quiet_a("t6", 300);
    check_eq("t6_model_flits", exp_flits, 12);
    check_stats("t6");
`ifdef NOC_TX_STATS_EN
    check_eq("t6_flit_count_12", a_flit_cnt, 12);
    check_eq("t6_pkt_count_3", a_pkt_cnt, 3);
    do_reset("t6_clear");
`endif

    check_eq("end_wr_tied", {a_wr_en, a_wr_data, b_wr_en, b_wr_data}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule : tb_noc_link_tx
